data_block_sequencer: RTL and testbench

Sequences complete SD data transfers, single- or multi-block, between the register/DMA side and the data physical layer (serializer, pad, FIFO path). It latches one transfer request and counts the blocks. For each block it waits for the physical layer and the FIFO, issues the per-block send, and polices the per-block timeout and CRC status. It then reports completion or error upstream. It replaces ad-hoc handshaking with one counted, timed controller.

---
 rtl/data_block_sequencer_if.sv | 55 +++++
 rtl/data_block_sequencer.sv | 175 +++++++++++++++++
 tb/tb_data_block_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_block_sequencer_if.sv
// -----------------------------------------------------------------------------
// data_block_sequencer_if
//   Bundles the request/configuration inputs, the physical-layer handshake and
//   the status outputs of the data block sequencer.
//   master : register/DMA + physical-layer side (drives requests and handshakes)
//   slave  : the sequencer itself
//   Signals:
//     iNewData, iWriteRead, iMultipleData, iBlocks, iTimeout_enable,
//     iTimeout_reg             transfer request and its configuration
//     iSerial_ready, iFIFO_ok  per-block readiness of serializer and FIFO
//     iBlock_done, iCrc_ok     per-block completion pulse and CRC status
//     iAbort                   terminate the current transfer
//     oSend .. oAborted        sequencing outputs and sticky status flags
// -----------------------------------------------------------------------------
interface data_block_sequencer_if #(
  parameter int BLOCK_W   = 4,
  parameter int TIMEOUT_W = 16
);
  logic                 iNewData;
  logic                 iWriteRead;
  logic                 iMultipleData;
  logic [BLOCK_W-1:0]   iBlocks;
  logic                 iTimeout_enable;
  logic [TIMEOUT_W-1:0] iTimeout_reg;
  logic                 iSerial_ready;
  logic                 iFIFO_ok;
  logic                 iBlock_done;
  logic                 iCrc_ok;
  logic                 iAbort;

  logic                 oSend;
  logic                 oWriteRead;
  logic                 oMultipleData;
  logic [BLOCK_W-1:0]   oBlock_index;
  logic                 oBusy;
  logic                 oIdle;
  logic                 oData_transfer_complete;
  logic                 oTimeout_oc;
  logic                 oCrc_error;
  logic                 oAborted;

  modport master (
    output iNewData, iWriteRead, iMultipleData, iBlocks, iTimeout_enable,
           iTimeout_reg, iSerial_ready, iFIFO_ok, iBlock_done, iCrc_ok, iAbort,
    input  oSend, oWriteRead, oMultipleData, oBlock_index, oBusy, oIdle,
           oData_transfer_complete, oTimeout_oc, oCrc_error, oAborted
  );

  modport slave (
    input  iNewData, iWriteRead, iMultipleData, iBlocks, iTimeout_enable,
           iTimeout_reg, iSerial_ready, iFIFO_ok, iBlock_done, iCrc_ok, iAbort,
    output oSend, oWriteRead, oMultipleData, oBlock_index, oBusy, oIdle,
           oData_transfer_complete, oTimeout_oc, oCrc_error, oAborted
  );
endinterface

// File: rtl/data_block_sequencer.sv
// -----------------------------------------------------------------------------
// data_block_sequencer
//   Sequences a complete SD data transfer (one block or a counted run of
//   blocks) between the register/DMA side and the data physical layer. One
//   request is latched; per block the controller waits for the serializer and
//   the FIFO, raises oSend, polices the block timeout and CRC status, and
//   finally pulses oData_transfer_complete.
//   Ports:
//     iClock  system clock (posedge)
//     iReset  asynchronous, active-high reset
//     bus     data_block_sequencer_if.slave: request/config inputs, block
//             handshake, sequencing outputs and sticky status flags
// -----------------------------------------------------------------------------
module data_block_sequencer #(
  parameter int BLOCK_W    = 4,
  parameter int TIMEOUT_W  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    iClock,
  input  logic                    iReset,
  data_block_sequencer_if.slave   bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_WAIT_FIFO,
    S_SEND,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q;
  logic                 to_en_q;
  logic [TIMEOUT_W-1:0] to_reg_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [BLOCK_W-1:0]   remaining_q;
  logic [GAP_W-1:0]     gap_q;

  logic                 send_q;
  logic                 wr_q;
  logic                 multi_q;
  logic [BLOCK_W-1:0]   idx_q;
  logic                 busy_q;
  logic                 idle_q;
  logic                 cpl_q;
  logic                 timeout_q;
  logic                 crc_err_q;
  logic                 aborted_q;

  logic [BLOCK_W-1:0]   start_blocks;
  logic                 active;

  // Single-block requests always move exactly one block.
  assign start_blocks = bus.iMultipleData ? bus.iBlocks : BLOCK_W'(1);

  // Abort is honoured only while a block run is in progress; DONE/ERROR are
  // already terminating and will complete on the next edge regardless.
  assign active = (state_q == S_WAIT_READY) || (state_q == S_WAIT_FIFO) ||
                  (state_q == S_SEND)       || (state_q == S_GAP);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      to_en_q     <= 1'b0;
      to_reg_q    <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      send_q      <= 1'b0;
      wr_q        <= 1'b0;
      multi_q     <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b1;
      cpl_q       <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      cpl_q <= 1'b0;
      if (active && bus.iAbort) begin
        // Abort outranks a same-cycle block completion: remaining and the
        // CRC flag are left untouched.
        aborted_q <= 1'b1;
        send_q    <= 1'b0;
        state_q   <= S_ERROR;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.iNewData) begin
              wr_q        <= bus.iWriteRead;
              multi_q     <= bus.iMultipleData;
              to_en_q     <= bus.iTimeout_enable;
              to_reg_q    <= bus.iTimeout_reg;
              remaining_q <= start_blocks;
              idx_q       <= '0;
              timeout_q   <= 1'b0;
              crc_err_q   <= 1'b0;
              aborted_q   <= 1'b0;
              busy_q      <= 1'b1;
              idle_q      <= 1'b0;
              state_q     <= (start_blocks == '0) ? S_DONE : S_WAIT_READY;
            end else begin
              busy_q <= 1'b0;
              idle_q <= 1'b1;
            end
          end
          S_WAIT_READY: begin
            if (bus.iSerial_ready) state_q <= S_WAIT_FIFO;
          end
          S_WAIT_FIFO: begin
            if (bus.iFIFO_ok) begin
              cnt_q   <= to_reg_q;
              send_q  <= 1'b1;
              state_q <= S_SEND;
            end
          end
          S_SEND: begin
            if (bus.iBlock_done) begin
              send_q <= 1'b0;
              if (!bus.iCrc_ok) begin
                crc_err_q <= 1'b1;
                state_q   <= S_ERROR;
              end else begin
                remaining_q <= remaining_q - 1'b1;
                if (remaining_q == BLOCK_W'(1)) begin
                  state_q <= S_DONE;
                end else begin
                  idx_q   <= idx_q + 1'b1;
                  gap_q   <= GAP_W'(GAP_CYCLES - 1);
                  state_q <= S_GAP;
                end
              end
            end else if (to_en_q) begin
              // Counter reaching zero with no completion still grants one
              // more cycle, so a load of N allows N+1 cycles in SEND.
              if (cnt_q == '0) begin
                send_q    <= 1'b0;
                timeout_q <= 1'b1;
                state_q   <= S_ERROR;
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end
          end
          S_GAP: begin
            if (gap_q == '0) state_q <= S_WAIT_READY;
            else             gap_q   <= gap_q - 1'b1;
          end
          S_DONE, S_ERROR: begin
            cpl_q   <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.oSend                   = send_q;
  assign bus.oWriteRead              = wr_q;
  assign bus.oMultipleData           = multi_q;
  assign bus.oBlock_index            = idx_q;
  assign bus.oBusy                   = busy_q;
  assign bus.oIdle                   = idle_q;
  assign bus.oData_transfer_complete = cpl_q;
  assign bus.oTimeout_oc             = timeout_q;
  assign bus.oCrc_error              = crc_err_q;
  assign bus.oAborted                = aborted_q;

endmodule

// File: tb/tb_data_block_sequencer.sv
module tb_data_block_sequencer;
  localparam int GAP = 2;

  logic iClock = 1'b0;
  logic iReset = 1'b1;

  data_block_sequencer_if #(.BLOCK_W(4), .TIMEOUT_W(16)) bus_if ();

  data_block_sequencer #(.BLOCK_W(4), .TIMEOUT_W(16), .GAP_CYCLES(GAP)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus_if)
  );

  always #5 iClock = ~iClock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the observable outputs plus a little transfer bookkeeping:
  // blocks left, per-block budget, gap cycles left, whether the serializer
  // has been seen ready for the next block, and a pending completion pulse.
  bit       m_send = 0, m_wr = 0, m_multi = 0, m_busy = 0, m_idle = 1, m_cpl = 0;
  bit       m_to = 0, m_crc = 0, m_ab = 0;
  logic [3:0] m_idx = '0;
  int       left = 0, budget = 0, gap_left = 0, to_reg = 0;
  bit       to_en = 0, got_ready = 0, ending = 0;

  task automatic m_reset();
    m_send = 0; m_wr = 0; m_multi = 0; m_busy = 0; m_idle = 1; m_cpl = 0;
    m_to = 0; m_crc = 0; m_ab = 0; m_idx = '0;
    left = 0; budget = 0; gap_left = 0; to_reg = 0; to_en = 0;
    got_ready = 0; ending = 0;
  endtask

  task automatic m_step();
    if (!m_busy || m_cpl) begin
      m_cpl = 0;
      if (bus_if.iNewData) begin
        m_wr = bus_if.iWriteRead; m_multi = bus_if.iMultipleData;
        to_en = bus_if.iTimeout_enable; to_reg = int'(bus_if.iTimeout_reg);
        left = bus_if.iMultipleData ? int'(bus_if.iBlocks) : 1;
        m_to = 0; m_crc = 0; m_ab = 0; m_idx = '0;
        m_busy = 1; m_idle = 0; got_ready = 0; gap_left = 0;
        ending = (left == 0);
      end else begin
        m_busy = 0; m_idle = 1;
      end
    end else if (ending) begin
      m_cpl = 1; ending = 0;
    end else if (bus_if.iAbort) begin
      m_ab = 1; m_send = 0; ending = 1;
    end else if (m_send) begin
      if (bus_if.iBlock_done) begin
        m_send = 0;
        if (!bus_if.iCrc_ok) begin
          m_crc = 1; ending = 1;
        end else begin
          left--;
          if (left == 0) ending = 1;
          else begin m_idx = m_idx + 4'd1; gap_left = GAP; got_ready = 0; end
        end
      end else if (to_en) begin
        if (budget == 0) begin m_to = 1; m_send = 0; ending = 1; end
        else budget--;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (!got_ready) begin
      if (bus_if.iSerial_ready) got_ready = 1;
    end else if (bus_if.iFIFO_ok) begin
      m_send = 1; budget = to_reg; got_ready = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge iClock or posedge iReset);
      if (iReset) m_reset();
      else        m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge iClock);
      chk("oSend",     32'(bus_if.oSend),                   32'(m_send));
      chk("oBusy",     32'(bus_if.oBusy),                   32'(m_busy));
      chk("oIdle",     32'(bus_if.oIdle),                   32'(m_idle));
      chk("oComplete", 32'(bus_if.oData_transfer_complete), 32'(m_cpl));
      chk("oIndex",    32'(bus_if.oBlock_index),            32'(m_idx));
      chk("oWR",       32'(bus_if.oWriteRead),              32'(m_wr));
      chk("oMulti",    32'(bus_if.oMultipleData),           32'(m_multi));
      chk("oTimeout",  32'(bus_if.oTimeout_oc),             32'(m_to));
      chk("oCrcErr",   32'(bus_if.oCrc_error),              32'(m_crc));
      chk("oAborted",  32'(bus_if.oAborted),                32'(m_ab));
    end
  end

  // ---------------- send-window monitor ----------------
  int  send_cycles = 0, windows = 0, cpl_cnt = 0, low_run = 0, min_low = 1000;
  bit  prev_send = 0;

  initial begin
    forever begin
      @(negedge iClock);
      if (bus_if.oData_transfer_complete) cpl_cnt++;
      if (bus_if.oSend) begin
        send_cycles++;
        if (!prev_send) begin
          if (windows > 0 && low_run < min_low) min_low = low_run;
          windows++;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_send = bus_if.oSend;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(negedge iClock);
    #1;
  endtask

  task automatic clear_mon();
    send_cycles = 0; windows = 0; cpl_cnt = 0; low_run = 0; min_low = 1000;
    prev_send = 0;
  endtask

  task automatic start(input bit wr, input bit multi, input logic [3:0] blocks,
                       input bit ten, input logic [15:0] treg);
    sync();
    clear_mon();
    bus_if.iNewData = 1; bus_if.iWriteRead = wr; bus_if.iMultipleData = multi;
    bus_if.iBlocks = blocks; bus_if.iTimeout_enable = ten; bus_if.iTimeout_reg = treg;
    sync();
    bus_if.iNewData = 0;
  endtask

  task automatic wait_send(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.oSend) begin ok = 1; break; end
      sync();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_if.oIdle && !bus_if.oBusy && !bus_if.oData_transfer_complete) begin
        ok = 1; break;
      end
      sync();
    end
    chk(name, 32'(ok), 32'd1);
    sync();
  endtask

  task automatic block_done(input bit crc);
    bus_if.iBlock_done = 1; bus_if.iCrc_ok = crc;
    sync();
    bus_if.iBlock_done = 0; bus_if.iCrc_ok = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    bus_if.iNewData = 0; bus_if.iWriteRead = 0; bus_if.iMultipleData = 0;
    bus_if.iBlocks = '0; bus_if.iTimeout_enable = 0; bus_if.iTimeout_reg = '0;
    bus_if.iSerial_ready = 1; bus_if.iFIFO_ok = 1; bus_if.iBlock_done = 0;
    bus_if.iCrc_ok = 1; bus_if.iAbort = 0;

    sync(); sync();
    chk("rst_idle",  32'(bus_if.oIdle), 32'd1);
    chk("rst_busy",  32'(bus_if.oBusy), 32'd0);
    chk("rst_send",  32'(bus_if.oSend), 32'd0);
    chk("rst_index", 32'(bus_if.oBlock_index), 32'd0);
    iReset = 0;
    sync();

    // Single block write, completion 10 cycles into the window.
    start(1, 0, 4'd0, 0, 16'd0);
    chk("single_busy_after_start", 32'(bus_if.oBusy), 32'd1);
    wait_send("single_wait_send");
    repeat (10) sync();
    block_done(1);
    wait_idle("single_wait_idle");
    chk("single_send_cycles", 32'(send_cycles), 32'd11);
    chk("single_windows",     32'(windows), 32'd1);
    chk("single_cpl",         32'(cpl_cnt), 32'd1);
    chk("single_wr",          32'(bus_if.oWriteRead), 32'd1);
    chk("single_flags",       32'({bus_if.oTimeout_oc, bus_if.oCrc_error, bus_if.oAborted}), 32'd0);

    // Three blocks.
    start(0, 1, 4'd3, 0, 16'd0);
    for (int b = 0; b < 3; b++) begin
      wait_send("multi_wait_send");
      chk("multi_index", 32'(bus_if.oBlock_index), 32'(b));
      repeat (3) sync();
      block_done(1);
    end
    wait_idle("multi_wait_idle");
    chk("multi_windows", 32'(windows), 32'd3);
    chk("multi_gap_ok",  32'(min_low >= GAP + 1), 32'd1);
    chk("multi_cpl",     32'(cpl_cnt), 32'd1);

    // Timeout with a budget of 5.
    start(0, 0, 4'd0, 1, 16'd5);
    wait_idle("to_wait_idle");
    chk("to_send_cycles", 32'(send_cycles), 32'd6);
    chk("to_flag",        32'(bus_if.oTimeout_oc), 32'd1);
    chk("to_cpl",         32'(cpl_cnt), 32'd1);

    // CRC failure on the second of four blocks.
    start(1, 1, 4'd4, 0, 16'd0);
    chk("crc_to_cleared", 32'(bus_if.oTimeout_oc), 32'd0);
    wait_send("crc_wait_send0");
    repeat (2) sync();
    block_done(1);
    wait_send("crc_wait_send1");
    repeat (2) sync();
    block_done(0);
    wait_idle("crc_wait_idle");
    chk("crc_flag",    32'(bus_if.oCrc_error), 32'd1);
    chk("crc_windows", 32'(windows), 32'd2);
    chk("crc_index",   32'(bus_if.oBlock_index), 32'd1);
    chk("crc_cpl",     32'(cpl_cnt), 32'd1);

    // Abort together with a good block completion.
    start(0, 1, 4'd2, 0, 16'd0);
    wait_send("abort_wait_send");
    bus_if.iAbort = 1; bus_if.iBlock_done = 1; bus_if.iCrc_ok = 1;
    sync();
    bus_if.iAbort = 0; bus_if.iBlock_done = 0;
    chk("abort_send_dropped", 32'(bus_if.oSend), 32'd0);
    wait_idle("abort_wait_idle");
    chk("abort_flag",    32'(bus_if.oAborted), 32'd1);
    chk("abort_crc",     32'(bus_if.oCrc_error), 32'd0);
    chk("abort_windows", 32'(windows), 32'd1);
    chk("abort_index",   32'(bus_if.oBlock_index), 32'd0);

    // Asynchronous reset in the middle of a window.
    start(1, 0, 4'd0, 0, 16'd0);
    wait_send("rst_mid_wait_send");
    #1 iReset = 1;
    #1;
    chk("rst_mid_send", 32'(bus_if.oSend), 32'd0);
    chk("rst_mid_busy", 32'(bus_if.oBusy), 32'd0);
    chk("rst_mid_idle", 32'(bus_if.oIdle), 32'd1);
    chk("rst_mid_wr",   32'(bus_if.oWriteRead), 32'd0);
    sync(); sync();
    iReset = 0;
    sync();

    // Stall: serializer not ready for 20 cycles, then FIFO not ready for 7.
    bus_if.iSerial_ready = 0; bus_if.iFIFO_ok = 0;
    start(0, 0, 4'd0, 0, 16'd0);
    repeat (20) sync();
    bus_if.iSerial_ready = 1;
    repeat (7) sync();
    chk("stall_no_send", 32'(send_cycles), 32'd0);
    bus_if.iFIFO_ok = 1;
    wait_send("stall_wait_send");
    block_done(1);
    wait_idle("stall_wait_idle");
    chk("stall_windows", 32'(windows), 32'd1);

    // Multi-block request with zero blocks.
    start(0, 1, 4'd0, 0, 16'd0);
    chk("zero_busy", 32'(bus_if.oBusy), 32'd1);
    sync();
    chk("zero_cpl_pulse", 32'(bus_if.oData_transfer_complete), 32'd1);
    wait_idle("zero_wait_idle");
    chk("zero_windows", 32'(windows), 32'd0);
    chk("zero_flags",   32'({bus_if.oTimeout_oc, bus_if.oCrc_error, bus_if.oAborted}), 32'd0);

    sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
